// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/data channels plus the BRAM pin bundle for mem_access_ctrl.
// Optional statistics signals exist only when MEM_ACCESS_STATS_EN is defined.
interface mem_access_ctrl_if #(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned LenWidth  = 4
);
    logic                 Req;
    logic                 Ready;
    logic                 Wr;
    logic [AddrWidth-1:0] StartAddr;
    logic [LenWidth-1:0]  BurstLen;
    logic                 WValid;
    logic                 WReady;
    logic [DataWidth-1:0] WData;
    logic                 RValid;
    logic [DataWidth-1:0] RData;
    logic                 Done;
    logic [AddrWidth-1:0] Mem_Addr;
    logic [DataWidth-1:0] Mem_DIn;
    logic [DataWidth-1:0] Mem_DOut;
    logic                 Mem_En_n;
    logic                 Mem_WE_n;
`ifdef MEM_ACCESS_STATS_EN
    logic                 StatsClr;
    logic [15:0]          RdCount;
    logic [15:0]          WrCount;

    modport slave (
        input  Req, Wr, StartAddr, BurstLen, WValid, WData, Mem_DOut, StatsClr,
        output Ready, WReady, RValid, RData, Done, Mem_Addr, Mem_DIn, Mem_En_n, Mem_WE_n,
        output RdCount, WrCount
    );

    modport master (
        output Req, Wr, StartAddr, BurstLen, WValid, WData, Mem_DOut, StatsClr,
        input  Ready, WReady, RValid, RData, Done, Mem_Addr, Mem_DIn, Mem_En_n, Mem_WE_n,
        input  RdCount, WrCount
    );
`else
    modport slave (
        input  Req, Wr, StartAddr, BurstLen, WValid, WData, Mem_DOut,
        output Ready, WReady, RValid, RData, Done, Mem_Addr, Mem_DIn, Mem_En_n, Mem_WE_n
    );

    modport master (
        output Req, Wr, StartAddr, BurstLen, WValid, WData, Mem_DOut,
        input  Ready, WReady, RValid, RData, Done, Mem_Addr, Mem_DIn, Mem_En_n, Mem_WE_n
    );
`endif
endinterface

// File: rtl/mem_access_ctrl.sv
// Burst read/write controller in front of a negedge-sampling single-port BRAM.
// Define MEM_ACCESS_STATS_EN to add saturating read/write beat counters.
module mem_access_ctrl #(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned LenWidth  = 4
) (
    input logic              Clk,
    input logic              Reset,
    mem_access_ctrl_if.slave bus
);
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRd     = 3'd1;
    localparam logic [2:0] StRdTail = 3'd2;
    localparam logic [2:0] StWr     = 3'd3;
    localparam logic [2:0] StWrTail = 3'd4;

    localparam logic [AddrWidth-1:0] AddrOne = 1;
    localparam logic [LenWidth:0]    BeatOne = 1;

    logic [2:0]           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    // Beats not yet issued to the BRAM.
    logic [LenWidth:0]    beats_q, beats_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 done_q, done_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0] mem_din_q, mem_din_d;
    logic                 mem_en_n_q, mem_en_n_d;
    logic                 mem_we_n_q, mem_we_n_d;

    logic ready;
    logic wready;

    assign ready  = (state_q == StIdle);
    assign wready = (state_q == StWr) && (beats_q != '0);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        done_d     = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_en_n_d = 1'b1;
        mem_we_n_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (bus.Req) begin
                    if (bus.Wr) begin
                        state_d = StWr;
                        addr_d  = bus.StartAddr;
                        beats_d = {1'b0, bus.BurstLen} + BeatOne;
                    end else begin
                        // First read beat is issued straight from the accept edge.
                        state_d    = StRd;
                        mem_addr_d = bus.StartAddr;
                        mem_en_n_d = 1'b0;
                        addr_d     = bus.StartAddr + AddrOne;
                        beats_d    = {1'b0, bus.BurstLen};
                    end
                end
            end
            StRd: begin
                rdata_d  = bus.Mem_DOut;
                rvalid_d = 1'b1;
                if (beats_q != '0) begin
                    mem_addr_d = addr_q;
                    mem_en_n_d = 1'b0;
                    addr_d     = addr_q + AddrOne;
                    beats_d    = beats_q - BeatOne;
                end else begin
                    state_d = StRdTail;
                    done_d  = 1'b1;
                end
            end
            StRdTail: begin
                state_d = StIdle;
            end
            StWr: begin
                if (bus.WValid && wready) begin
                    mem_din_d  = bus.WData;
                    mem_addr_d = addr_q;
                    mem_en_n_d = 1'b0;
                    mem_we_n_d = 1'b0;
                    addr_d     = addr_q + AddrOne;
                    beats_d    = beats_q - BeatOne;
                    if (beats_q == BeatOne) begin
                        state_d = StWrTail;
                    end
                end
            end
            StWrTail: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            beats_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_en_n_q <= 1'b1;
            mem_we_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_en_n_q <= mem_en_n_d;
            mem_we_n_q <= mem_we_n_d;
        end
    end

    assign bus.Ready    = ready;
    assign bus.WReady   = wready;
    assign bus.RValid   = rvalid_q;
    assign bus.RData    = rdata_q;
    assign bus.Done     = done_q;
    assign bus.Mem_Addr = mem_addr_q;
    assign bus.Mem_DIn  = mem_din_q;
    assign bus.Mem_En_n = mem_en_n_q;
    assign bus.Mem_WE_n = mem_we_n_q;

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    // Counts the registered enable, i.e. cycles the BRAM really sees an access.
    always_ff @(posedge Clk) begin
        if (Reset || bus.StatsClr) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (!mem_en_n_q && mem_we_n_q && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (!mem_en_n_q && !mem_we_n_q && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign bus.RdCount = rd_count_q;
    assign bus.WrCount = wr_count_q;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a negedge-registered 256x16 BRAM model.
// Statistics checks are built only when MEM_ACCESS_STATS_EN is defined.
module tb_mem_access_ctrl;
    logic Clk = 1'b0;
    logic Reset;

    mem_access_ctrl_if #(.AddrWidth(8), .DataWidth(16), .LenWidth(4)) bus ();

    mem_access_ctrl #(.AddrWidth(8), .DataWidth(16), .LenWidth(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // BRAM model: samples on negedge, registered DOut; preload port for setup.
    logic [15:0] bram [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    initial bus.Mem_DOut = 16'h0;

    always @(negedge Clk) begin
        if (pl_en) begin
            bram[pl_addr] <= pl_data;
        end else if (!bus.Mem_En_n) begin
            if (!bus.Mem_WE_n) bram[bus.Mem_Addr] <= bus.Mem_DIn;
            else bus.Mem_DOut <= bram[bus.Mem_Addr];
        end
    end

    int rv_count = 0;
    int done_count = 0;
    always @(posedge Clk) begin
        if (bus.RValid) rv_count <= rv_count + 1;
        if (bus.Done) done_count <= done_count + 1;
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic request(input logic wr, input logic [7:0] a, input logic [3:0] len);
        bus.Req       = 1'b1;
        bus.Wr        = wr;
        bus.StartAddr = a;
        bus.BurstLen  = len;
    endtask

    int rv_base;
    int done_base;

    initial begin
        Reset         = 1'b1;
        bus.Req       = 1'b0;
        bus.Wr        = 1'b0;
        bus.StartAddr = 8'h0;
        bus.BurstLen  = 4'h0;
        bus.WValid    = 1'b0;
        bus.WData     = 16'h0;
`ifdef MEM_ACCESS_STATS_EN
        bus.StatsClr  = 1'b0;
`endif
        pl_en   = 1'b0;
        pl_addr = 8'h0;
        pl_data = 16'h0;
        for (int i = 0; i < 256; i++) bram[i] = 16'h0;

        tick();
        tick();
        check("rst_ready", bus.Ready, 1);
        check("rst_wready", bus.WReady, 0);
        check("rst_rvalid", bus.RValid, 0);
        check("rst_rdata", bus.RData, 0);
        check("rst_done", bus.Done, 0);
        check("rst_addr", bus.Mem_Addr, 0);
        check("rst_din", bus.Mem_DIn, 0);
        check("rst_en_n", bus.Mem_En_n, 1);
        check("rst_we_n", bus.Mem_WE_n, 1);
        Reset = 1'b0;

        for (int i = 0; i < 4; i++) preload(8'(8'h10 + i), 16'(16'hA000 + i));

        // WValid in IDLE must not touch the BRAM.
        bus.WValid = 1'b1;
        bus.WData  = 16'hDEAD;
        tick();
        check("idle_wvalid_en_n", bus.Mem_En_n, 1);
        check("idle_wready", bus.WReady, 0);
        bus.WValid = 1'b0;

        // 4-beat read at 0x10.
        request(1'b0, 8'h10, 4'd3);
        tick();
        bus.Req = 1'b0;
        check("rd_ready_busy", bus.Ready, 0);
        check("rd_en_n", bus.Mem_En_n, 0);
        check("rd_we_n", bus.Mem_WE_n, 1);
        check("rd_addr0", bus.Mem_Addr, 8'h10);
        check("rd_rvalid_early", bus.RValid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_rvalid", bus.RValid, 1);
            check("rd_rdata", bus.RData, 16'(16'hA000 + i));
            check("rd_done", bus.Done, (i == 3) ? 1 : 0);
        end
        check("rd_tail_en_n", bus.Mem_En_n, 1);
        tick();
        check("rd_ready_back", bus.Ready, 1);
        check("rd_rvalid_end", bus.RValid, 0);
        check("rd_done_end", bus.Done, 0);

        // 3-beat write at 0xFE with one bubble; wraps to 0x00.
        done_base = done_count;
        request(1'b1, 8'hFE, 4'd2);
        tick();
        bus.Req = 1'b0;
        check("wr_wready", bus.WReady, 1);
        check("wr_idle_en_n", bus.Mem_En_n, 1);
        bus.WValid = 1'b1;
        bus.WData  = 16'h1111;
        tick();
        check("wr_b0_en_n", bus.Mem_En_n, 0);
        check("wr_b0_we_n", bus.Mem_WE_n, 0);
        check("wr_b0_addr", bus.Mem_Addr, 8'hFE);
        check("wr_b0_din", bus.Mem_DIn, 16'h1111);
        bus.WValid = 1'b0;
        tick();
        check("wr_bubble_en_n", bus.Mem_En_n, 1);
        bus.WValid = 1'b1;
        bus.WData  = 16'h2222;
        tick();
        check("wr_b1_addr", bus.Mem_Addr, 8'hFF);
        check("wr_b1_en_n", bus.Mem_En_n, 0);
        bus.WData = 16'h3333;
        tick();
        bus.WValid = 1'b0;
        check("wr_b2_addr", bus.Mem_Addr, 8'h00);
        check("wr_tail_wready", bus.WReady, 0);
        check("wr_tail_done", bus.Done, 0);
        tick();
        check("wr_done", bus.Done, 1);
        check("wr_ready_back", bus.Ready, 1);
        check("wr_end_en_n", bus.Mem_En_n, 1);
        tick();
        check("wr_done_pulses", done_count - done_base, 1);
        check("wr_mem_fe", bram[8'hFE], 16'h1111);
        check("wr_mem_ff", bram[8'hFF], 16'h2222);
        check("wr_mem_00", bram[8'h00], 16'h3333);

        // Req held through a 4-beat read is not queued.
        rv_base = rv_count;
        request(1'b0, 8'h10, 4'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_ready_low", bus.Ready, 0);
            tick();
        end
        check("hold_ready_high", bus.Ready, 1);
        check("hold_rvalid_count", rv_count - rv_base, 4);
        tick();
        check("hold_second_accept", bus.Ready, 0);
        bus.Req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("hold_idle_again", bus.Ready, 1);

        // Reset during beat 2 of an 8-beat write at 0x40.
        done_base = done_count;
        request(1'b1, 8'h40, 4'd7);
        tick();
        bus.Req    = 1'b0;
        bus.WValid = 1'b1;
        bus.WData  = 16'h5000;
        tick();
        bus.WData = 16'h5001;
        tick();
        Reset = 1'b1;
        tick();
        check("rst_mid_en_n", bus.Mem_En_n, 1);
        check("rst_mid_we_n", bus.Mem_WE_n, 1);
        check("rst_mid_ready", bus.Ready, 1);
        check("rst_mid_done", bus.Done, 0);
        Reset      = 1'b0;
        bus.WValid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("rst_mid_no_done", done_count - done_base, 0);
        check("rst_mid_mem_40", bram[8'h40], 16'h5000);
        check("rst_mid_mem_41", bram[8'h41], 16'h5001);
        check("rst_mid_mem_42", bram[8'h42], 16'h0000);

        // Single write of 0xBEEF to 0x00, then single read back.
        request(1'b1, 8'h00, 4'd0);
        tick();
        bus.Req    = 1'b0;
        bus.WValid = 1'b1;
        bus.WData  = 16'hBEEF;
        tick();
        bus.WValid = 1'b0;
        tick();
        check("single_wr_done", bus.Done, 1);
        request(1'b0, 8'h00, 4'd0);
        tick();
        bus.Req = 1'b0;
        check("single_rd_rvalid_early", bus.RValid, 0);
        tick();
        check("single_rd_rvalid", bus.RValid, 1);
        check("single_rd_rdata", bus.RData, 16'hBEEF);
        check("single_rd_done", bus.Done, 1);
        tick();
        check("single_rd_ready", bus.Ready, 1);
        check("single_rd_rvalid_end", bus.RValid, 0);

`ifdef MEM_ACCESS_STATS_EN
        bus.StatsClr = 1'b1;
        tick();
        bus.StatsClr = 1'b0;
        check("stats_clr_rd", bus.RdCount, 0);
        request(1'b0, 8'h10, 4'd2);
        tick();
        bus.Req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        request(1'b1, 8'h80, 4'd1);
        tick();
        bus.Req    = 1'b0;
        bus.WValid = 1'b1;
        bus.WData  = 16'h7777;
        tick();
        tick();
        bus.WValid = 1'b0;
        tick();
        tick();
        check("stats_rd", bus.RdCount, 3);
        check("stats_wr", bus.WrCount, 2);
        bus.StatsClr = 1'b1;
        tick();
        bus.StatsClr = 1'b0;
        check("stats_clr_rd2", bus.RdCount, 0);
        check("stats_clr_wr2", bus.WrCount, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
